// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and a queued long-latency result stream.
// Optional forwarding lookup into the queue is built when WB_ARB_FWD_EN is defined.
module wb_port_arbiter #(
    parameter int DEPTH      = 4,
    parameter int MAX_WAIT   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pipe_valid_in,
    output logic                           pipe_ready_out,
    input  logic [DATA_WIDTH-1:0]          pipe_data_in,
    input  logic [ID_WIDTH-1:0]            pipe_rd_in,
    input  logic                           ll_valid_in,
    output logic                           ll_ready_out,
    input  logic [DATA_WIDTH-1:0]          ll_data_in,
    input  logic [ID_WIDTH-1:0]            ll_rd_in,
    output logic [DATA_WIDTH-1:0]          regs_data_out,
    output logic [ID_WIDTH-1:0]            regs_wr_id_out,
    output logic                           regs_write_out,
    output logic [$clog2(DEPTH+1)-1:0]     pending_out
`ifdef WB_ARB_FWD_EN
    ,
    input  logic [ID_WIDTH-1:0]            fwd_rd_in,
    output logic                           fwd_hit_out,
    output logic [DATA_WIDTH-1:0]          fwd_data_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [AGE_W-1:0]      age_q, age_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ID_WIDTH-1:0]   rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic                  regs_write_d;
    logic [ID_WIDTH-1:0]   regs_wr_id_d;
    logic [DATA_WIDTH-1:0] regs_data_d;

    logic forceDrain;
    logic pipeWrite;
    logic llEnqueue;
    logic headPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Once the head has waited MAX_WAIT cycles the pipe is held off so the port goes idle and the head drains.
    assign forceDrain     = (count_q != '0) && (age_q >= AGE_W'(MAX_WAIT));
    assign pipe_ready_out = !forceDrain;
    assign ll_ready_out   = (count_q < CNT_W'(DEPTH));
    assign pending_out    = count_q;

    // rd==0 requests complete their handshake but never reach the port or the queue.
    assign pipeWrite = pipe_valid_in && pipe_ready_out && (pipe_rd_in != '0);
    assign llEnqueue = ll_valid_in && ll_ready_out && (ll_rd_in != '0);
    assign headPop   = !pipeWrite && (count_q != '0);

    always_comb begin
        head_d       = headPop ? nextPtr(head_q) : head_q;
        tail_d       = llEnqueue ? nextPtr(tail_q) : tail_q;
        count_d      = count_q;
        age_d        = age_q;
        valid_d      = valid_q;
        regs_write_d = 1'b0;
        regs_wr_id_d = '0;
        regs_data_d  = '0;

        if (llEnqueue && !headPop) begin
            count_d = count_q + 1'b1;
        end else if (!llEnqueue && headPop) begin
            count_d = count_q - 1'b1;
        end

        if (headPop || (count_q == '0)) begin
            age_d = '0;
        end else if (age_q < AGE_W'(MAX_WAIT)) begin
            age_d = age_q + 1'b1;
        end

        // A pipe write is younger than every queued result for its rd, so those results become dead.
        if (pipeWrite) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == pipe_rd_in) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
        if (headPop) begin
            valid_d[head_q] = 1'b0;
        end
        if (llEnqueue) begin
            valid_d[tail_q] = 1'b1;
        end

        if (pipeWrite) begin
            regs_write_d = 1'b1;
            regs_wr_id_d = pipe_rd_in;
            regs_data_d  = pipe_data_in;
        end else if (headPop && valid_q[head_q]) begin
            regs_write_d = 1'b1;
            regs_wr_id_d = rd_q[head_q];
            regs_data_d  = data_q[head_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            age_q          <= '0;
            valid_q        <= '0;
            regs_write_out <= 1'b0;
            regs_wr_id_out <= '0;
            regs_data_out  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            age_q          <= age_d;
            valid_q        <= valid_d;
            regs_write_out <= regs_write_d;
            regs_wr_id_out <= regs_wr_id_d;
            regs_data_out  <= regs_data_d;
            if (llEnqueue) begin
                rd_q[tail_q]   <= ll_rd_in;
                data_q[tail_q] <= ll_data_in;
            end
        end
    end

`ifdef WB_ARB_FWD_EN
    int fwdSlot;

    // Walk from head to tail so the last match seen is the youngest live entry.
    always_comb begin
        fwd_hit_out  = 1'b0;
        fwd_data_out = '0;
        fwdSlot      = 0;
        for (int i = 0; i < DEPTH; i++) begin
            fwdSlot = int'(head_q) + i;
            if (fwdSlot >= DEPTH) begin
                fwdSlot = fwdSlot - DEPTH;
            end
            if ((i < int'(count_q)) && valid_q[PTR_W'(fwdSlot)] &&
                (rd_q[PTR_W'(fwdSlot)] == fwd_rd_in) && (fwd_rd_in != '0)) begin
                fwd_hit_out  = 1'b1;
                fwd_data_out = data_q[PTR_W'(fwdSlot)];
            end
        end
    end
`endif

endmodule
